// File: rtl/booth_pkg.sv
// booth_pkg: shared types and helpers for the radix-4 Booth sequential multiplier.
// Holds the FSM state encoding, the Booth digit representation, the triplet
// encoder and the digit-count helper used to size the iteration loop.
package booth_pkg;

    // Controller states: waiting for operands, retiring digits, holding a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } booth_state_t;

    // One radix-4 Booth digit in sign/magnitude form.
    // Value = (neg ? -1 : +1) * (two ? 2 : one ? 1 : 0).
    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

    // Recode the triplet {x[2k+1], x[2k], x[2k-1]} into a digit in {-2..+2}.
    // 3'b111 is encoded as a plain zero (neg cleared) so it contributes no
    // negate carry into the accumulator.
    function automatic booth_digit_t booth_encode(input logic [2:0] trip);
        booth_digit_t d;
        d = '0;
        case (trip)
            3'b001,
            3'b010: d.one = 1'b1;                 // +1
            3'b011: d.two = 1'b1;                 // +2
            3'b100: begin                         // -2
                d.neg = 1'b1;
                d.two = 1'b1;
            end
            3'b101,
            3'b110: begin                         // -1
                d.neg = 1'b1;
                d.one = 1'b1;
            end
            default: d = '0;                      // 000, 111 -> 0
        endcase
        return d;
    endfunction

    // Number of Booth digits needed for an exact product. Unsigned operands
    // need one extra digit so the zero-extended top bit is recoded.
    function automatic int booth_digits(input int width, input logic signed_mode);
        return signed_mode ? (width / 2) : (width / 2 + 1);
    endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// booth_pp_sel: combinational partial-product selector for one Booth digit.
// Picks 0, 1x or 2x of the extended multiplicand and, for negative digits,
// outputs the one's complement; the +1 that completes the two's complement is
// returned separately as neg_carry so it can ride in the accumulator add.
module booth_pp_sel
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  booth_digit_t       digit,
    input  logic [WIDTH+1:0]   mcand,
    output logic [WIDTH+2:0]   pp,
    output logic               neg_carry
);

    logic [WIDTH+2:0] mcand_x1;
    logic [WIDTH+2:0] mcand_x2;
    logic [WIDTH+2:0] mag;

    // The extended multiplicand only uses WIDTH+1 significant bits, so a
    // one-bit left shift into WIDTH+3 bits is exact.
    assign mcand_x1 = {mcand[WIDTH+1], mcand};
    assign mcand_x2 = {mcand, 1'b0};

    // Select the digit magnitude.
    always_comb begin
        mag = '0;
        if (digit.one) begin
            mag = mcand_x1;
        end else if (digit.two) begin
            mag = mcand_x2;
        end
    end

    // Conditional inversion, bit by bit.
    generate
        for (genvar gi = 0; gi < WIDTH + 3; gi++) begin : g_inv
            assign pp[gi] = mag[gi] ^ digit.neg;
        end
    endgenerate

    assign neg_carry = digit.neg;

endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: iterative radix-4 Booth multiplier, one digit per cycle.
// Valid/ready on both sides; the result is held in DONE until accepted.
// Optional build macro BOOTH_ZERO_SKIP_EN: a zero operand finishes after a
// single BUSY cycle with a zero product instead of walking every digit.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int ACC_W      = 2 * WIDTH + 4;
    localparam int N_SIGNED   = booth_digits(WIDTH, 1'b1);
    localparam int N_UNSIGNED = booth_digits(WIDTH, 1'b0);
    localparam int CNT_W      = $clog2(N_UNSIGNED + 1);

    // Reject operand widths the digit recoding cannot handle.
    generate
        if ((WIDTH % 2 != 0) || (WIDTH < 4)) begin : g_bad_width
            $error("booth_mult_seq: WIDTH must be even and >= 4");
        end
    endgenerate

    // Architectural state
    booth_state_t          state_reg, state_next;
    logic [WIDTH+2:0]      x_reg, x_next;        // {x_ext, x[-1]}, shifts right 2 per digit
    logic [WIDTH+1:0]      y_reg, y_next;        // extended multiplicand
    logic [CNT_W-1:0]      cnt_reg, cnt_next;    // digit index k
    logic [CNT_W-1:0]      last_reg, last_next;  // index of the final digit
    logic [ACC_W-1:0]      acc_reg, acc_next;
    logic [2*WIDTH-1:0]    product_reg, product_next;
    logic                  out_valid_reg, out_valid_next;
`ifdef BOOTH_ZERO_SKIP_EN
    logic                  zero_reg, zero_next;  // a captured operand was zero
`endif

    // Datapath wires
    booth_digit_t          digit;
    logic [WIDTH+2:0]      pp;
    logic                  neg_carry;
    logic [ACC_W-1:0]      pp_ext;
    logic [ACC_W-1:0]      cin_ext;
    logic [CNT_W:0]        shamt;
    logic [ACC_W-1:0]      acc_sum;
    logic [WIDTH+1:0]      x_ext;
    logic [WIDTH+1:0]      y_ext;
    logic                  last_digit;

    // Operand extension at capture: sign- or zero-extend by two bits.
    assign x_ext = is_signed ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
    assign y_ext = is_signed ? {{2{y[WIDTH-1]}}, y} : {2'b00, y};

    // The low three bits of the shifting multiplier are always the current triplet.
    assign digit = booth_encode(x_reg[2:0]);

    booth_pp_sel #(
        .WIDTH (WIDTH)
    ) u_pp_sel (
        .digit     (digit),
        .mcand     (y_reg),
        .pp        (pp),
        .neg_carry (neg_carry)
    );

    // Weight the partial product and its negate carry by 4^k in one add.
    assign pp_ext  = {{(WIDTH + 1){pp[WIDTH+2]}}, pp};
    assign cin_ext = ACC_W'(neg_carry);
    assign shamt   = {cnt_reg, 1'b0};
    assign acc_sum = acc_reg + (pp_ext << shamt) + (cin_ext << shamt);

`ifdef BOOTH_ZERO_SKIP_EN
    assign last_digit = (cnt_reg == last_reg) || zero_reg;
`else
    assign last_digit = (cnt_reg == last_reg);
`endif

    // Handshake outputs; in_ready is masked by RESET so nothing is accepted
    // on a cycle that is about to be discarded.
    assign in_ready  = (state_reg == IDLE) && !RESET;
    assign out_valid = out_valid_reg;
    assign product   = product_reg;
    assign busy      = (state_reg != IDLE);

    // Next-state, datapath update and result capture.
    always_comb begin
        state_next     = state_reg;
        x_next         = x_reg;
        y_next         = y_reg;
        cnt_next       = cnt_reg;
        last_next      = last_reg;
        acc_next       = acc_reg;
        product_next   = product_reg;
        out_valid_next = out_valid_reg;
`ifdef BOOTH_ZERO_SKIP_EN
        zero_next      = zero_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (in_valid && in_ready) begin
                    x_next     = {x_ext, 1'b0};
                    y_next     = y_ext;
                    cnt_next   = '0;
                    acc_next   = '0;
                    last_next  = is_signed ? CNT_W'(N_SIGNED - 1) : CNT_W'(N_UNSIGNED - 1);
`ifdef BOOTH_ZERO_SKIP_EN
                    zero_next  = (x == '0) || (y == '0);
`endif
                    state_next = BUSY;
                end
            end
            BUSY: begin
                x_next   = x_reg >> 2;
                acc_next = acc_sum;
                cnt_next = cnt_reg + CNT_W'(1);
                if (last_digit) begin
`ifdef BOOTH_ZERO_SKIP_EN
                    product_next = zero_reg ? '0 : acc_sum[2*WIDTH-1:0];
`else
                    product_next = acc_sum[2*WIDTH-1:0];
`endif
                    out_valid_next = 1'b1;
                    state_next     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                out_valid_next = 1'b0;
                state_next     = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= IDLE;
            x_reg         <= '0;
            y_reg         <= '0;
            cnt_reg       <= '0;
            last_reg      <= '0;
            acc_reg       <= '0;
            product_reg   <= '0;
            out_valid_reg <= 1'b0;
`ifdef BOOTH_ZERO_SKIP_EN
            zero_reg      <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            x_reg         <= x_next;
            y_reg         <= y_next;
            cnt_reg       <= cnt_next;
            last_reg      <= last_next;
            acc_reg       <= acc_next;
            product_reg   <= product_next;
            out_valid_reg <= out_valid_next;
`ifdef BOOTH_ZERO_SKIP_EN
            zero_reg      <= zero_next;
`endif
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: directed vector table plus handshake, backpressure and
// mid-operation reset sequences for booth_mult_seq at WIDTH=8.
module tb_booth_mult_seq;

    localparam int W = 8;

    logic           CLK = 1'b0;
    logic           RESET;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic           is_signed;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic           busy;

    int checks = 0;
    int passes = 0;

    booth_mult_seq #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]  vx;
        logic [7:0]  vy;
        logic        vs;
        logic [15:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one operand pair, measure latency from the handshake edge,
    // return the product and optionally release it.
    task automatic run_op(input logic [7:0] ax, input logic [7:0] ay, input logic as,
                          input bit release_it, output logic [15:0] p, output int lat);
        @(negedge CLK);
        x         = ax;
        y         = ay;
        is_signed = as;
        in_valid  = 1'b1;
        @(posedge CLK);                  // edge 0: handshake
        #1;
        in_valid  = 1'b0;
        x         = 8'hxx;
        y         = 8'hxx;
        lat       = -1;
        p         = 16'hxxxx;
        for (int c = 1; c <= 20; c++) begin
            @(posedge CLK);
            #1;
            if (out_valid) begin
                lat = c;
                p   = product;
                break;
            end
        end
        if (release_it && lat > 0) begin
            out_ready = 1'b1;
            @(posedge CLK);
            #1;
            out_ready = 1'b0;
        end
    endtask

    localparam int ZLAT =
`ifdef BOOTH_ZERO_SKIP_EN
        1;
`else
        4;
`endif

    vec_t        vecs [16];
    logic [15:0] p;
    int          lat;
    logic [15:0] held;
    logic [7:0]  rx, ry;
    logic        rs;
    logic [15:0] rexp;
    bit          stable_ok;
    bit          queued;

    initial begin
        vecs[0]  = '{8'h80, 8'h80, 1'b1, 16'h4000, 4};  // -128 * -128
        vecs[1]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, 5};  // 255 * 255
        vecs[2]  = '{8'hFF, 8'h01, 1'b1, 16'hFFFF, 4};  // -1 * 1
        vecs[3]  = '{8'h03, 8'hF9, 1'b1, 16'hFFEB, 4};  // 3 * -7
        vecs[4]  = '{8'h07, 8'h09, 1'b0, 16'h003F, 5};  // 7 * 9
        vecs[5]  = '{8'h00, 8'h5A, 1'b1, 16'h0000, ZLAT};
        vecs[6]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01, 4};  // 127 * 127
        vecs[7]  = '{8'h80, 8'h7F, 1'b1, 16'hC080, 4};  // -128 * 127
        vecs[8]  = '{8'h80, 8'h80, 1'b0, 16'h4000, 5};  // 128 * 128
        vecs[9]  = '{8'hFF, 8'h80, 1'b0, 16'h7F80, 5};  // 255 * 128
        vecs[10] = '{8'h05, 8'h80, 1'b1, 16'hFD80, 4};  // 5 * -128
        vecs[11] = '{8'hC8, 8'h03, 1'b0, 16'h0258, 5};  // 200 * 3
        vecs[12] = '{8'hFD, 8'hFD, 1'b1, 16'h0009, 4};  // -3 * -3
        vecs[13] = '{8'h55, 8'hAA, 1'b1, 16'hE372, 4};  // 85 * -86
        vecs[14] = '{8'hFF, 8'h80, 1'b1, 16'h0080, 4};  // -1 * -128
        vecs[15] = '{8'hFF, 8'h00, 1'b0, 16'h0000, (ZLAT == 1) ? 1 : 5};

        RESET     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        y         = '0;
        is_signed = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        RESET = 1'b0;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Directed table
        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].vx, vecs[i].vy, vecs[i].vs, 1'b1, p, lat);
            $display("vec %0d: x=0x%02h y=0x%02h signed=%0d -> product=0x%04h latency=%0d",
                     i, vecs[i].vx, vecs[i].vy, vecs[i].vs, p, lat);
            check($sformatf("vec%0d_product", i), 32'(p), 32'(vecs[i].exp));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Backpressure: hold the result for 10 cycles while poking in_valid.
        run_op(8'h03, 8'hF9, 1'b1, 1'b0, p, lat);
        check("bp_product", 32'(p), 32'h0000FFEB);
        held      = product;
        stable_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            in_valid = c[0];
            x        = 8'h11;
            y        = 8'h22;
            @(posedge CLK);
            #1;
            if (product !== held || !out_valid || in_ready || !busy) stable_ok = 1'b0;
        end
        in_valid = 1'b0;
        check("bp_held_stable", 32'(stable_ok), 32'd1);
        $display("backpressure: product=0x%04h held for 10 cycles", held);
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        queued = 1'b0;
        repeat (8) begin
            @(posedge CLK);
            #1;
            if (out_valid || busy) queued = 1'b1;
        end
        check("bp_no_queued_op", 32'(queued), 32'd0);

        // Reset during the second BUSY cycle.
        @(negedge CLK);
        x = 8'd100; y = 8'd100; is_signed = 1'b1; in_valid = 1'b1;
        @(posedge CLK);                  // edge 0
        #1;
        in_valid = 1'b0;
        @(posedge CLK);                  // edge 1, second BUSY cycle follows
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_product", 32'(product), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        RESET = 1'b0;
        #1;
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        $display("mid-op reset: out_valid=%0d product=0x%04h busy=%0d", out_valid, product, busy);
        run_op(8'd7, 8'd9, 1'b0, 1'b1, p, lat);
        $display("after reset: 7*9 -> %0d latency=%0d", p, lat);
        check("rst_then_7x9", 32'(p), 32'd63);

        // Random operands against a reference multiply.
        for (int i = 0; i < 60; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            rs = i[0];
            if (rs) rexp = 16'(int'($signed(rx)) * int'($signed(ry)));
            else    rexp = 16'(int'(rx) * int'(ry));
            run_op(rx, ry, rs, 1'b1, p, lat);
            $display("rand %0d: x=0x%02h y=0x%02h signed=%0d -> product=0x%04h", i, rx, ry, rs, p);
            check($sformatf("rand%0d_product", i), 32'(p), 32'(rexp));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
